filter_pad_gen: RTL

FILTER_PAD_GEN -- requirements
Module: filter_pad_gen

---
 rtl/filter_pad_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/filter_pad_gen.sv
// Zero-padding frame generator: wraps each W x H source image in a P-pixel zero border
// and streams the padded raster to a KxK filter, one o_rotate pulse per padded pixel.
module filter_pad_gen #(
  parameter int img_width   = 320,
  parameter int img_height  = 240,
  parameter int kernel_size = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_rotate,
  output logic [7:0] o_data,
  output logic       o_sof,
  output logic       o_frame_done,
  output logic       o_busy,
  output logic [2:0] state_dbg
);

  localparam int P = (kernel_size - 1) / 2;

  localparam logic [12:0] COL_LAST      = 13'(img_width + 2 * P - 1);
  localparam logic [12:0] LEFT_LAST     = 13'(P - 1);
  localparam logic [12:0] DATA_LAST     = 13'(P + img_width - 1);
  localparam logic [12:0] TOP_ROW_LAST  = 13'(P - 1);
  localparam logic [12:0] DATA_ROW_LAST = 13'(P + img_height - 1);
  localparam logic [12:0] ROW_LAST      = 13'(img_height + 2 * P - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOP    = 3'd1,
    LEFT   = 3'd2,
    DATA   = 3'd3,
    RIGHT  = 3'd4,
    BOTTOM = 3'd5,
    END    = 3'd6
  } state_t;

  // Handshake: a source pixel moves only on a cycle where i_valid and o_ready are both 1;
  // o_rotate marks every cycle on which o_data carries a padded pixel.

  state_t      state, state_next;
  logic [12:0] col, row;
  logic        advance;
  logic        col_wrap;
  logic        rotate_d, sof_d, done_d;
  logic [7:0]  data_d;

  assign col_wrap  = (col == COL_LAST);
  assign state_dbg = state;
  assign o_ready   = (state == DATA);
  assign o_busy    = (state != IDLE);

  // A padded pixel is produced on every border cycle, and on DATA cycles only when a pixel arrives.
  always_comb begin
    advance = 1'b0;
    case (state)
      TOP, LEFT, RIGHT, BOTTOM: advance = 1'b1;
      DATA:                     advance = i_valid;
      default:                  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (i_valid) state_next = TOP;
      TOP:    if (row == TOP_ROW_LAST && col_wrap) state_next = LEFT;
      LEFT:   if (col == LEFT_LAST) state_next = DATA;
      DATA:   if (i_valid && col == DATA_LAST) state_next = RIGHT;
      RIGHT:  if (col_wrap) state_next = (row == DATA_ROW_LAST) ? BOTTOM : LEFT;
      BOTTOM: if (row == ROW_LAST && col_wrap) state_next = END;
      END:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rotate_d = advance;
    data_d   = (state == DATA && i_valid) ? i_data : 8'd0;
    sof_d    = (state == TOP) && (row == 13'd0) && (col == 13'd0);
    done_d   = (state == END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= 13'd0;
      row <= 13'd0;
    end else if (state == END) begin
      col <= 13'd0;
      row <= 13'd0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= 13'd0;
        row <= row + 13'd1;
      end else begin
        col <= col + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rotate     <= 1'b0;
      o_data       <= 8'd0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_rotate     <= rotate_d;
      o_data       <= data_d;
      o_sof        <= sof_d;
      o_frame_done <= done_d;
    end
  end

endmodule
